// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for mem_port_arbiter: FSM state values and port-owner codes.
package mem_arb_defs;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational grant selection between the instruction and data ports.
// ARB_ROUND_ROBIN_EN switches ties from fixed data priority to alternating.
module arb_pick
  import mem_arb_defs::*;
(
  input  logic i_req,
  input  logic d_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic last_owner,
`endif
  output logic grant
);

  always_comb begin
    grant = OWN_D;
`ifdef ARB_ROUND_ROBIN_EN
    if (i_req && d_req) begin
      grant = (last_owner == OWN_D) ? OWN_I : OWN_D;
    end else if (i_req) begin
      grant = OWN_I;
    end
`else
    if (i_req && !d_req) begin
      grant = OWN_I;
    end
`endif
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one busywait-style memory between instruction-fetch and data ports.
// Optional ARB_ROUND_ROBIN_EN macro: ties alternate instead of favouring data.
module mem_port_arbiter
  import mem_arb_defs::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_readdata,
  output logic              i_busywait,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_writedata,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-3:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait,
  output arb_state_t        dbg_state,
  output logic              dbg_owner
);

  // Handshake: a requester holds its request and operands while its busywait
  // is high; busywait drops for exactly the DONE cycle of that port's access,
  // and the requester may advance at the following edge.

  arb_state_t state_q, state_d;
  logic       owner_q;
  logic       busy_entry_q;
  logic       grant;
  logic       i_req, d_req, any_req;
  logic       finish;
  logic       unused_addr_bits;

  assign i_req   = i_read;
  assign d_req   = d_read || d_write;
  assign any_req = i_req || d_req;

  // Byte-offset bits never reach the word-addressed memory.
  assign unused_addr_bits = ^{i_address[1:0], d_address[1:0]};

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner_q;

  arb_pick u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_owner (last_owner_q),
    .grant      (grant)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      last_owner_q <= OWN_D;
    end else if (state_q == IDLE && any_req) begin
      last_owner_q <= grant;
    end
  end
`else
  arb_pick u_pick (
    .i_req (i_req),
    .d_req (d_req),
    .grant (grant)
  );
`endif

  // The memory's busywait is not trusted in the BUSY entry cycle.
  assign finish = (state_q == BUSY) && !busy_entry_q && !mem_busywait;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = BUSY;
      BUSY:    if (finish)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      owner_q       <= OWN_D;
      busy_entry_q  <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
      i_readdata    <= '0;
      d_readdata    <= '0;
    end else begin
      busy_entry_q <= 1'b0;
      if (state_q == IDLE && any_req) begin
        owner_q      <= grant;
        busy_entry_q <= 1'b1;
        if (grant == OWN_D) begin
          mem_address   <= d_address[ADDR_W-1:2];
          mem_writedata <= d_writedata;
          mem_write     <= d_write;
          mem_read      <= !d_write;
        end else begin
          mem_address <= i_address[ADDR_W-1:2];
          mem_write   <= 1'b0;
          mem_read    <= 1'b1;
        end
      end
      if (finish) begin
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
        if (mem_read) begin
          if (owner_q == OWN_D) d_readdata <= mem_readdata;
          else                  i_readdata <= mem_readdata;
        end
      end
    end
  end

  assign i_busywait = i_req && !(state_q == DONE && owner_q == OWN_I);
  assign d_busywait = d_req && !(state_q == DONE && owner_q == OWN_D);

  assign dbg_state = state_q;
  assign dbg_owner = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural memory, port drivers, scoreboard.
module tb_mem_port_arbiter;
  import mem_arb_defs::*;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int WORDS  = 256;

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic TIE_FIRST = OWN_I;
`else
  localparam logic TIE_FIRST = OWN_D;
`endif

  logic              CLK = 1'b0;
  logic              RESET;
  logic              i_read, d_read, d_write;
  logic [ADDR_W-1:0] i_address, d_address;
  logic [DATA_W-1:0] i_readdata, d_readdata, d_writedata;
  logic              i_busywait, d_busywait;
  logic              mem_read, mem_write, mem_busywait;
  logic [ADDR_W-3:0] mem_address;
  logic [DATA_W-1:0] mem_writedata, mem_readdata;
  arb_state_t        dbg_state;
  logic              dbg_owner;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [DATA_W-1:0] mem_arr [WORDS];
  logic [DATA_W-1:0] ref_mem [WORDS];
  logic [DATA_W-1:0] i_exp_q [$];
  logic [DATA_W-1:0] d_exp_q [$];
  logic              done_order [$];
  int                done_cyc [$];
  logic [DATA_W-1:0] d_last;

  int                force_extra = -1;
  logic [ADDR_W-3:0] last_addr;
  logic [DATA_W-1:0] last_wdata;
  logic              last_wr;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK(CLK), .RESET(RESET),
    .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata), .i_busywait(i_busywait),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
    .d_readdata(d_readdata), .d_busywait(d_busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait),
    .dbg_state(dbg_state), .dbg_owner(dbg_owner)
  );

  // Clock / watchdog
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Behavioural memory: random latency, entry-cycle busywait is noise.
  int                k, extra;
  bit                m_act, pend_done;
  logic              a_rd, a_wr;
  logic [ADDR_W-3:0] a_addr;
  logic [DATA_W-1:0] a_data;

  always @(negedge CLK) begin
    if (RESET) begin
      m_act = 0; pend_done = 0; mem_busywait = 1'b0; mem_readdata = '0;
    end else begin
      if (pend_done) begin
        pend_done = 0;
        check(dbg_state === DONE, "done_state", dbg_state, DONE);
        check({mem_read, mem_write} === 2'b00, "done_strobes", {mem_read, mem_write}, 0);
      end
      if (m_act) begin
        check({mem_read, mem_write} === {a_rd, a_wr}, "hold_strobe", {mem_read, mem_write}, {a_rd, a_wr});
        check(mem_address === a_addr, "hold_addr", mem_address, a_addr);
        if (a_wr) check(mem_writedata === a_data, "hold_wdata", mem_writedata, a_data);
        k++;
        if (k == extra + 1) begin
          mem_busywait = 1'b0;
          if (a_wr) mem_arr[a_addr] = a_data;
          else      mem_readdata = mem_arr[a_addr];
          m_act = 0; pend_done = 1;
        end else begin
          mem_busywait = 1'b1;
          mem_readdata = $urandom;
        end
      end else if (mem_read || mem_write) begin
        m_act = 1; k = 0;
        a_rd = mem_read; a_wr = mem_write; a_addr = mem_address; a_data = mem_writedata;
        last_addr = mem_address; last_wdata = mem_writedata; last_wr = mem_write;
        extra = (force_extra >= 0) ? force_extra : int'($urandom_range(0, 3));
        check(dbg_state === BUSY, "entry_state", dbg_state, BUSY);
        mem_busywait = (force_extra >= 0) ? (force_extra > 0) : 1'($urandom_range(0, 1));
        mem_readdata = $urandom;
      end else begin
        mem_busywait = 1'($urandom_range(0, 1));
        mem_readdata = $urandom;
      end
    end
  end

  // Scoreboard monitor: pops on every DONE cycle a requester sees.
  logic [DATA_W-1:0] exp_v;
  always @(negedge CLK) begin
    if (!RESET) begin
      if (i_read && !i_busywait) begin
        check(dbg_state === DONE && dbg_owner === OWN_I, "i_done_owner", {dbg_state, dbg_owner}, {DONE, OWN_I});
        check(i_exp_q.size() > 0, "i_exp_empty", i_exp_q.size(), 1);
        if (i_exp_q.size() > 0) begin
          exp_v = i_exp_q.pop_front();
          check(i_readdata === exp_v, "i_readdata", i_readdata, exp_v);
        end
        done_order.push_back(OWN_I); done_cyc.push_back(cyc);
      end
      if ((d_read || d_write) && !d_busywait) begin
        check(dbg_state === DONE && dbg_owner === OWN_D, "d_done_owner", {dbg_state, dbg_owner}, {DONE, OWN_D});
        check(d_exp_q.size() > 0, "d_exp_empty", d_exp_q.size(), 1);
        if (d_exp_q.size() > 0) begin
          exp_v = d_exp_q.pop_front();
          check(d_readdata === exp_v, "d_readdata", d_readdata, exp_v);
        end
        done_order.push_back(OWN_D); done_cyc.push_back(cyc);
      end
    end
  end

  // Drivers: called 1ns after a rising edge, return 1ns after the advance edge.
  task automatic i_access(input logic [ADDR_W-1:0] addr);
    bit seen = 0;
    i_address = addr;
    i_exp_q.push_back(ref_mem[addr[ADDR_W-1:2]]);
    i_read = 1'b1;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge CLK);
      if (!i_busywait) seen = 1;
    end
    check(seen, "i_timeout", seen, 1);
    @(posedge CLK); #1;
    i_read = 1'b0;
    i_address = 10'($urandom);
  endtask

  task automatic d_access(input logic [ADDR_W-1:0] addr, input bit wr, input bit both,
                          input logic [DATA_W-1:0] wdata);
    bit seen = 0;
    if (wr) ref_mem[addr[ADDR_W-1:2]] = wdata;
    else    d_last = ref_mem[addr[ADDR_W-1:2]];
    d_exp_q.push_back(d_last);
    d_address = addr; d_writedata = wdata;
    d_write = wr; d_read = !wr || both;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge CLK);
      if (!d_busywait) seen = 1;
    end
    check(seen, "d_timeout", seen, 1);
    @(posedge CLK); #1;
    d_read = 1'b0; d_write = 1'b0;
    d_writedata = $urandom;
  endtask

  initial begin
    bit   seen;
    int   p, dc;
    RESET = 1'b1; i_read = 0; d_read = 0; d_write = 0;
    i_address = '0; d_address = '0; d_writedata = '0; d_last = '0;
    for (int w = 0; w < WORDS; w++) begin
      mem_arr[w] = $urandom;
      ref_mem[w] = mem_arr[w];
    end

    // Reset values
    repeat (2) @(posedge CLK); #1;
    i_read = 1'b1; #1;
    check(i_busywait === 1'b1, "rst_i_busywait", i_busywait, 1);
    check(dbg_state === IDLE, "rst_state", dbg_state, IDLE);
    check({mem_read, mem_write} === 2'b00, "rst_strobes", {mem_read, mem_write}, 0);
    check(mem_address === '0, "rst_mem_address", mem_address, 0);
    check(mem_writedata === '0, "rst_mem_writedata", mem_writedata, 0);
    check(i_readdata === '0 && d_readdata === '0, "rst_readdata", {i_readdata, d_readdata}, 0);
    i_read = 1'b0;
    @(negedge CLK); #2 RESET = 1'b0;
    @(posedge CLK); #1;

    // Simultaneous requests: order and loser latency
    force_extra = 0;
    for (int t = 0; t < 2; t++) begin
      done_order.delete(); done_cyc.delete();
      fork
        i_access({1'b0, 7'($urandom_range(0, 127)), 2'b00});
        d_access({1'b1, 7'($urandom_range(0, 127)), 2'b00}, 1'b0, 1'b0, '0);
      join
      check(done_order.size() == 2, "tie_count", done_order.size(), 2);
      if (done_order.size() == 2) begin
        check(done_order[0] === TIE_FIRST && done_order[1] === !TIE_FIRST, "tie_order",
              {done_order[0], done_order[1]}, {TIE_FIRST, !TIE_FIRST});
        check(done_cyc[1] - done_cyc[0] == 4, "tie_loser_wait", done_cyc[1] - done_cyc[0], 4);
      end
    end

    // Instruction fetch, best-case memory, entry busywait low but ignored
    mem_arr[3] = 32'hDEADBEEF; ref_mem[3] = 32'hDEADBEEF;
    done_cyc.delete();
    p = cyc;
    i_access(10'h00C);
    check(last_addr === 8'h03 && last_wr === 1'b0, "i_fetch_addr", last_addr, 8'h03);
    check(i_readdata === 32'hDEADBEEF, "i_fetch_data", i_readdata, 32'hDEADBEEF);
    check(done_cyc.size() == 1 && done_cyc[0] - p == 3, "i_fetch_latency", done_cyc.size() > 0 ? done_cyc[0] - p : -1, 3);

    // Data write then read back, byte-offset bits ignored
    d_access(10'h010, 1'b1, 1'b0, 32'h12345678);
    check(last_addr === 8'h04 && last_wr === 1'b1, "d_write_addr", {last_wr, last_addr}, {1'b1, 8'h04});
    check(last_wdata === 32'h12345678, "d_write_data", last_wdata, 32'h12345678);
    d_access(10'h013, 1'b0, 1'b0, '0);
    d_access(10'h200, 1'b1, 1'b1, 32'hCAFE0001);
    d_access(10'h201, 1'b0, 1'b0, '0);

    // Long memory stall; request dropped mid-access
    force_extra = 4;
    d_address = 10'h320; d_read = 1'b1;
    p = cyc;
    repeat (3) @(posedge CLK); #1;
    d_read = 1'b0;
    seen = 0; dc = 0;
    for (int n = 0; n < 30 && !seen; n++) begin
      @(negedge CLK);
      if (dbg_state == DONE) begin seen = 1; dc = cyc; end
    end
    check(seen, "stall_done_seen", seen, 1);
    check(dc - p == 7, "stall_latency", dc - p, 7);
    @(negedge CLK);
    check(dbg_state === IDLE, "stall_then_idle", dbg_state, IDLE);
    check(d_readdata === ref_mem[8'hC8], "stall_readdata", d_readdata, ref_mem[8'hC8]);
    d_last = ref_mem[8'hC8];
    @(posedge CLK); #1;

    // Randomized concurrent traffic on both ports
    force_extra = -1;
    fork
      for (int n = 0; n < 40; n++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
        i_access({1'b0, 7'($urandom_range(0, 127)), 2'($urandom)});
      end
      for (int n = 0; n < 40; n++) begin
        bit wr;
        repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
        wr = ($urandom_range(0, 2) == 0);
        d_access({1'b1, 7'($urandom_range(0, 127)), 2'($urandom)}, wr, wr && 1'($urandom), $urandom);
      end
    join

    // Asynchronous reset during a stalled write
    force_extra = 6;
    d_address = 10'h3F0; d_writedata = 32'hA5A50F0F; d_write = 1'b1;
    repeat (3) @(posedge CLK); #1;
    check(mem_write === 1'b1, "pre_rst_write", mem_write, 1);
    #1 RESET = 1'b1; #1;
    check(mem_write === 1'b0, "rst_async_write", mem_write, 0);
    check(dbg_state === IDLE, "rst_async_state", dbg_state, IDLE);
    check(d_readdata === '0 && i_readdata === '0, "rst_async_readdata", {i_readdata, d_readdata}, 0);
    check(d_busywait === 1'b1, "rst_async_busywait", d_busywait, 1);
    d_write = 1'b0;
    @(negedge CLK); #2 RESET = 1'b0;
    d_last = '0; force_extra = -1;
    @(posedge CLK); #1;
    d_access(10'h3F0, 1'b0, 1'b0, '0);
    i_access(10'h00C);

    repeat (4) @(posedge CLK);
    check(i_exp_q.size() == 0 && d_exp_q.size() == 0, "queues_drained",
          i_exp_q.size() + d_exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
